pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the architectural PC and sequences instruction fetch around it.
- Issues one instruction-memory request at a time and presents the returned instruction to decode with a valid/ready handshake.
- Applies branch/jump redirects and trap vectors with fixed priority, and discards in-flight fetches made stale by a redirect.
- Sits between the PC register path and decode; replaces free-running PC update with a flow-controlled one.

Parameters:
- DATA_WIDTH, 64, PC/address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_VECTOR, 64'h0, PC loaded on reset.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_redirect_valid  input  1  branch/jump taken this cycle.
- i_redirect_pc  input  DATA_WIDTH  redirect target.
- i_trap_valid  input  1  trap/exception taken this cycle.
- i_trap_vector  input  DATA_WIDTH  trap handler address.
- o_imem_req_valid  output  1  fetch request valid.
- o_imem_addr  output  DATA_WIDTH  fetch address (equals o_pc).
- i_imem_req_ready  input  1  memory accepts request.
- i_imem_rsp_valid  input  1  response data valid (one per accepted request).
- i_imem_rsp_data  input  INSTR_WIDTH  fetched instruction.
- o_instr_valid  output  1  instruction available to decode.
- o_instr  output  INSTR_WIDTH  held instruction.
- o_instr_pc  output  DATA_WIDTH  PC of o_instr.
- i_instr_ready  input  1  decode consumes instruction.
- o_pc  output  DATA_WIDTH  current fetch PC.
- o_misaligned  output  1  redirect/trap target had addr[1:0]!=0; level, held until next valid trap.

Behaviour:
- Reset is sampled only on a rising i_clk edge with i_rst_n=0. Reset values:
  - state=FETCH, o_pc=RESET_VECTOR
  - o_instr_valid=0, o_instr=0, o_instr_pc=0, o_misaligned=0
  - o_imem_req_valid=0 during the reset cycle; registered, so it rises on the first cycle after reset release.
- o_imem_req_valid is registered: 1 exactly in state FETCH. o_imem_addr = o_pc.
- Handshakes:
  - Request fires on req_valid&req_ready.
  - Instruction transfer fires on o_instr_valid&i_instr_ready.
  - At most one request is outstanding. Responses arrive in order, at least 1 cycle after acceptance.
- States:
  - FETCH: on request fire -> WAIT_RSP.
  - WAIT_RSP: on rsp_valid -> latch data into o_instr, o_instr_pc=o_pc; o_pc<=o_pc+4 (mod 2^DATA_WIDTH); -> HOLD.
  - HOLD: o_instr_valid=1; o_instr/o_instr_pc stable. On transfer -> FETCH (next request the following cycle; back-to-back fetch throughput 1 instr per 3 cycles minimum).
  - FLUSH: waiting for a stale response. On rsp_valid, the data is dropped -> FETCH.
  - HALT: no requests, o_instr_valid=0; exits only on trap.
- Redirect priority: trap > redirect > sequential. Target T = trap_vector if i_trap_valid, else redirect_pc. Loaded as o_pc<=T next cycle.
- Redirect by state:
  - FETCH without fire: request is withdrawn (permitted on this port); stay FETCH at T.
  - FETCH with fire same cycle, or WAIT_RSP without rsp_valid: -> FLUSH.
  - WAIT_RSP with rsp_valid same cycle: response dropped -> FETCH.
  - HOLD: o_instr_valid drops next cycle, instruction discarded even if i_instr_ready=1 that cycle (decode must also flush) -> FETCH.
  - FLUSH: o_pc updated to newest T; stay FLUSH.
- Misaligned target (T[1:0]!=0): o_pc<=T, o_misaligned<=1, state follows the redirect rules above, except the destination FETCH becomes HALT (FLUSH still drains first, then HALT). A trap with an aligned vector clears o_misaligned.
- A rsp_valid with no outstanding request is ignored.

Decomposition:
- Shared package core_pkg: fetch_state_e enum (FETCH, WAIT_RSP, HOLD, FLUSH, HALT), INSTR_BYTES=4, RESET_VECTOR default.
- Optional sub-module fetch_target_sel: combinational priority mux producing T and its misaligned flag.
- The PC register stays local to this block.

Test Plan:
- Reset release, req_ready=1, rsp 2 cycles later with 32'h00000013, i_instr_ready=1 -> addr 0 requested, then o_instr=13/o_instr_pc=0, then addr 4 requested.
- i_instr_ready=0 for 5 cycles in HOLD -> o_instr/o_instr_pc stable, no new request, o_pc=4.
- Redirect to 64'h1000 during WAIT_RSP -> FLUSH; stale rsp dropped (o_instr_valid stays 0); next request addr 64'h1000.
- Trap (vector 64'h200) and redirect (64'h1000) in same cycle -> o_pc=64'h200.
- Redirect to 64'h1002 -> o_misaligned=1, HALT, no requests; trap to 64'h200 -> misaligned cleared, fetch 64'h200.
- Reset asserted in HOLD -> next cycle o_instr_valid=0, o_pc=RESET_VECTOR, state FETCH.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-path types and constants for the core front end.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH,
        WAIT_RSP,
        HOLD,
        FLUSH,
        HALT
    } fetch_state_e;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

endpackage

// File: rtl/fetch_target_sel.sv
// Priority mux for control-flow targets: a trap always beats a branch/jump redirect.
module fetch_target_sel #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_redirect_valid,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    input  logic                  i_trap_valid,
    input  logic [DATA_WIDTH-1:0] i_trap_vector,
    output logic                  o_valid,
    output logic                  o_is_trap,
    output logic [DATA_WIDTH-1:0] o_target,
    output logic                  o_misaligned
);

    always_comb begin
        o_valid      = i_trap_valid | i_redirect_valid;
        o_is_trap    = i_trap_valid;
        o_target     = i_trap_valid ? i_trap_vector : i_redirect_pc;
        o_misaligned = (o_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the architectural PC and sequences one-at-a-time instruction fetch into decode,
// applying trap/redirect targets and draining stale responses.
module pc_fetch_sequencer
    import core_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    INSTR_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_redirect_valid,
    input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
    input  logic                   i_trap_valid,
    input  logic [DATA_WIDTH-1:0]  i_trap_vector,
    output logic                   o_imem_req_valid,
    output logic [DATA_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_req_ready,
    input  logic                   i_imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0]  o_instr_pc,
    input  logic                   i_instr_ready,
    output logic [DATA_WIDTH-1:0]  o_pc,
    output logic                   o_misaligned
);

    fetch_state_e           r_state, w_nextState, w_redirDest;
    logic [DATA_WIDTH-1:0]  r_pc, w_nextPc, r_instrPc, w_target;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_reqValid, r_misaligned, w_nextMisaligned;
    logic                   w_targetValid, w_targetIsTrap, w_targetMis;
    logic                   w_applyRedirect, w_destMis, w_reqFire, w_xferFire, w_capture;

    fetch_target_sel #(.DATA_WIDTH(DATA_WIDTH)) u_targetSel (
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .i_trap_valid     (i_trap_valid),
        .i_trap_vector    (i_trap_vector),
        .o_valid          (w_targetValid),
        .o_is_trap        (w_targetIsTrap),
        .o_target         (w_target),
        .o_misaligned     (w_targetMis)
    );

    // HALT ignores plain redirects; only a trap can restart fetch from there.
    always_comb begin
        w_reqFire        = r_reqValid & i_imem_req_ready & (r_state == FETCH);
        w_xferFire       = (r_state == HOLD) & i_instr_ready;
        w_applyRedirect  = w_targetIsTrap | (w_targetValid & (r_state != HALT));
        w_destMis        = w_targetIsTrap ? w_targetMis : (r_misaligned | w_targetMis);
        w_redirDest      = w_destMis ? HALT : FETCH;
        w_nextState      = r_state;
        w_nextPc         = r_pc;
        w_nextMisaligned = r_misaligned;
        w_capture        = 1'b0;

        if (w_applyRedirect) begin
            w_nextPc         = w_target;
            w_nextMisaligned = w_destMis;
        end

        case (r_state)
            FETCH: begin
                if (w_applyRedirect)
                    w_nextState = w_reqFire ? FLUSH : w_redirDest;
                else if (w_reqFire)
                    w_nextState = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (w_applyRedirect) begin
                    w_nextState = i_imem_rsp_valid ? w_redirDest : FLUSH;
                end else if (i_imem_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_nextPc    = r_pc + DATA_WIDTH'(INSTR_BYTES);
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_applyRedirect)
                    w_nextState = w_redirDest;
                else if (w_xferFire)
                    w_nextState = FETCH;
            end
            FLUSH: begin
                if (i_imem_rsp_valid)
                    w_nextState = w_nextMisaligned ? HALT : FETCH;
            end
            HALT: begin
                if (w_applyRedirect)
                    w_nextState = w_redirDest;
            end
            default: w_nextState = FETCH;
        endcase
    end

    // Request valid is registered off the next state so it never glitches with ready.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= FETCH;
            r_pc         <= RESET_VECTOR;
            r_reqValid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_instr      <= '0;
            r_instrPc    <= '0;
        end else begin
            r_state      <= w_nextState;
            r_pc         <= w_nextPc;
            r_reqValid   <= (w_nextState == FETCH);
            r_misaligned <= w_nextMisaligned;
            if (w_capture) begin
                r_instr   <= i_imem_rsp_data;
                r_instrPc <= r_pc;
            end
        end
    end

    assign o_imem_req_valid = r_reqValid;
    assign o_imem_addr      = r_pc;
    assign o_pc             = r_pc;
    assign o_instr_valid    = (r_state == HOLD);
    assign o_instr          = r_instr;
    assign o_instr_pc       = r_instrPc;
    assign o_misaligned     = r_misaligned;

endmodule
